// File: rtl/hazard_scheduler.sv
// Issue scheduler between fetch and decode. A per-register scoreboard holds fetch on RAW hazards,
// and the scheduler also inserts bubbles, flushes slots after taken branches and latches HALT.
module hazard_scheduler #(
  parameter int unsigned WB_DIST     = 3,
  parameter int unsigned FLUSH_SLOTS = 2
) (
  input  logic        clockp2,
  input  logic        reset,
  input  logic [15:0] command_in,
  input  logic        cmd_valid_in,
  input  logic        branch_taken,
  output logic        stall,
  output logic [15:0] command_out,
  output logic        cmd_valid_out,
  output logic        halted,
  output logic [7:0]  pending_mask,
  output logic [15:0] stall_count
);

  localparam int unsigned CW   = 3;
  localparam int unsigned NREG = 8;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt [NREG];
  logic [CW-1:0]   cnt_nxt [NREG];
  logic [NREG-1:0] mask_nxt;
  logic [CW-1:0]   flush_cnt;

  logic [CW-1:0] src_a, src_b, dst;
  logic          use_a, use_b, has_dst, is_halt;
  logic          hazard, issue;

  // Decode source/destination registers of the instruction presented by fetch
  always_comb begin
    src_a   = command_in[13:11];
    src_b   = command_in[10:8];
    dst     = command_in[10:8];
    use_a   = 1'b0;
    use_b   = 1'b0;
    has_dst = 1'b0;
    is_halt = 1'b0;
    if (command_in != 16'h0000) begin
      case (command_in[15:14])
        2'd3: begin
          use_a   = 1'b1;
          use_b   = 1'b1;
          has_dst = !(command_in[7:4] inside {4'd5, 4'd13, 4'd14, 4'd15});
          is_halt = (command_in[7:4] == 4'd15);
        end
        2'd0: begin
          use_b   = 1'b1;
          dst     = command_in[13:11];
          has_dst = 1'b1;
        end
        2'd1: begin
          use_a = 1'b1;
          use_b = 1'b1;
        end
        default: begin
          if (command_in[13:11] == 3'd0) begin
            has_dst = 1'b1;
          end else if (command_in[13:11] inside {3'd1, 3'd2, 3'd3}) begin
            use_b   = 1'b1;
            has_dst = (command_in[13:11] != 3'd3);
          end
        end
      endcase
    end
  end

  // Hazard check uses pre-decrement counter values
  always_comb begin
    hazard = cmd_valid_in && (state == RUN) &&
             ((use_a && (cnt[src_a] != '0)) || (use_b && (cnt[src_b] != '0)));
    stall  = hazard || (state != RUN);
    issue  = (state == RUN) && !branch_taken && cmd_valid_in && !hazard;
  end

  // Counters drain every cycle; an issuing writer reloads its destination
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = (cnt[i] != '0) ? cnt[i] - CW'(1) : '0;
    end
    if (issue && has_dst) begin
      cnt_nxt[dst] = CW'(WB_DIST);
    end
    for (int i = 0; i < NREG; i++) begin
      mask_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clockp2) begin
    if (reset) begin
      state         <= RUN;
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      flush_cnt     <= '0;
      command_out   <= 16'h0000;
      cmd_valid_out <= 1'b0;
      halted        <= 1'b0;
      pending_mask  <= '0;
      stall_count   <= 16'h0000;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      pending_mask  <= mask_nxt;
      command_out   <= 16'h0000;
      cmd_valid_out <= 1'b0;
      case (state)
        RUN: begin
          if (branch_taken) begin
            state     <= FLUSH;
            flush_cnt <= CW'(FLUSH_SLOTS - 1);
          end else if (hazard) begin
            if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
          end else if (issue) begin
            command_out   <= command_in;
            cmd_valid_out <= 1'b1;
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (branch_taken) begin
            flush_cnt <= CW'(FLUSH_SLOTS - 1);
          end else if (flush_cnt == '0) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: vector table for scoreboard timing, hand sequences for
// branch flush, HALT and stall-counter saturation.
module tb_hazard_scheduler;

  logic        clockp2 = 1'b0;
  logic        reset, cmd_valid_in, branch_taken;
  logic [15:0] command_in;
  logic        stall, cmd_valid_out, halted;
  logic [15:0] command_out, stall_count;
  logic [7:0]  pending_mask;

  logic        reset_s, cmd_valid_s, branch_s;
  logic [15:0] command_s;
  logic        stall_s, cmd_valid_out_s, halted_s;
  logic [15:0] command_out_s, stall_count_s;
  logic [7:0]  pending_mask_s;

  int checks = 0;
  int errors = 0;

  always #5 clockp2 = ~clockp2;

  hazard_scheduler dut (
    .clockp2(clockp2), .reset(reset), .command_in(command_in), .cmd_valid_in(cmd_valid_in),
    .branch_taken(branch_taken), .stall(stall), .command_out(command_out),
    .cmd_valid_out(cmd_valid_out), .halted(halted), .pending_mask(pending_mask),
    .stall_count(stall_count)
  );

  hazard_scheduler #(.WB_DIST(7), .FLUSH_SLOTS(2)) dut_sat (
    .clockp2(clockp2), .reset(reset_s), .command_in(command_s), .cmd_valid_in(cmd_valid_s),
    .branch_taken(branch_s), .stall(stall_s), .command_out(command_out_s),
    .cmd_valid_out(cmd_valid_out_s), .halted(halted_s), .pending_mask(pending_mask_s),
    .stall_count(stall_count_s)
  );

  typedef struct {
    logic [15:0] cmd;
    logic        v;
    logic        es;
    logic [15:0] eo;
    logic        ev;
    logic [7:0]  epm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] cmd, logic v, logic es, logic [15:0] eo, logic ev,
                              logic [7:0] epm);
    vec_t r;
    r.cmd = cmd; r.v = v; r.es = es; r.eo = eo; r.ev = ev; r.epm = epm;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // One cycle on the main DUT: drive, check stall before the edge, registered outputs after
  task automatic step(input string nm, input logic [15:0] cmd, input logic v, input logic br,
                      input logic es, input logic [15:0] eo, input logic ev, input logic eh);
    @(negedge clockp2);
    command_in = cmd; cmd_valid_in = v; branch_taken = br;
    #1 chk({nm, " stall"}, 32'(stall), 32'(es));
    @(posedge clockp2);
    #1;
    chk({nm, " cmd_out"}, 32'(command_out), 32'(eo));
    chk({nm, " vout"}, 32'(cmd_valid_out), 32'(ev));
    chk({nm, " halted"}, 32'(halted), 32'(eh));
  endtask

  initial begin
    reset = 1'b1; command_in = 16'h0000; cmd_valid_in = 1'b0; branch_taken = 1'b0;
    reset_s = 1'b1; command_s = 16'h0000; cmd_valid_s = 1'b0; branch_s = 1'b0;

    // T1/T2/T3 scoreboard timing, with idle gaps so each pair starts drained
    tbl.push_back(mk(16'hD100, 1, 0, 16'hD100, 1, 8'h02));
    tbl.push_back(mk(16'hCB00, 1, 1, 16'h0000, 0, 8'h02));
    tbl.push_back(mk(16'hCB00, 1, 1, 16'h0000, 0, 8'h02));
    tbl.push_back(mk(16'hCB00, 1, 1, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(16'hCB00, 1, 0, 16'hCB00, 1, 8'h08));
    tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 8'h08));
    tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 8'h08));
    tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(16'h8205, 1, 0, 16'h8205, 1, 8'h04));
    tbl.push_back(mk(16'hC300, 1, 0, 16'hC300, 1, 8'h0C));
    tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 8'h0C));
    tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 8'h08));
    tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(16'h2100, 1, 0, 16'h2100, 1, 8'h10));
    tbl.push_back(mk(16'h6400, 1, 1, 16'h0000, 0, 8'h10));
    tbl.push_back(mk(16'h6400, 1, 1, 16'h0000, 0, 8'h10));
    tbl.push_back(mk(16'h6400, 1, 1, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(16'h6400, 1, 0, 16'h6400, 1, 8'h00));
    tbl.push_back(mk(16'h5100, 1, 0, 16'h5100, 1, 8'h00));
    tbl.push_back(mk(16'hCB00, 1, 0, 16'hCB00, 1, 8'h08));
    tbl.push_back(mk(16'h5B00, 0, 0, 16'h0000, 0, 8'h08));
    tbl.push_back(mk(16'h5B00, 1, 1, 16'h0000, 0, 8'h08));
    tbl.push_back(mk(16'h5B00, 1, 1, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(16'h5B00, 1, 0, 16'h5B00, 1, 8'h00));
    tbl.push_back(mk(16'h8900, 1, 0, 16'h8900, 1, 8'h02));

    repeat (2) @(posedge clockp2);
    #1;
    chk("rst cmd_out", 32'(command_out), 32'h0);
    chk("rst vout", 32'(cmd_valid_out), 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst pmask", 32'(pending_mask), 32'h0);
    chk("rst scount", 32'(stall_count), 32'h0);
    @(negedge clockp2);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clockp2);
      command_in = tbl[i].cmd; cmd_valid_in = tbl[i].v; branch_taken = 1'b0;
      #1 chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].es));
      @(posedge clockp2);
      #1;
      chk($sformatf("v%0d cmd_out", i), 32'(command_out), 32'(tbl[i].eo));
      chk($sformatf("v%0d vout", i), 32'(cmd_valid_out), 32'(tbl[i].ev));
      chk($sformatf("v%0d pmask", i), 32'(pending_mask), 32'(tbl[i].epm));
    end
    chk("table scount", 32'(stall_count), 32'd8);

    // T4: branch while 0xCB00 waits on r1; two flush cycles, then a fresh fetch issues
    step("t4 hz", 16'hCB00, 1, 0, 1, 16'h0000, 0, 0);
    step("t4 br", 16'hCB00, 1, 1, 1, 16'h0000, 0, 0);
    step("t4 f1", 16'hCB00, 1, 0, 1, 16'h0000, 0, 0);
    step("t4 f2", 16'hCB00, 1, 0, 1, 16'h0000, 0, 0);
    step("t4 nx", 16'hC300, 1, 0, 0, 16'hC300, 1, 0);
    chk("t4 scount", 32'(stall_count), 32'd9);

    // T5: HALT issues once and then everything is a bubble until reset
    step("t5 hlt", 16'hC0F0, 1, 0, 0, 16'hC0F0, 1, 1);
    for (int i = 0; i < 3; i++) step($sformatf("t5 h%0d", i), 16'hD100, 1, 0, 1, 16'h0000, 0, 1);
    step("t5 hbr", 16'hD100, 1, 1, 1, 16'h0000, 0, 1);
    chk("t5 scount", 32'(stall_count), 32'd9);
    @(negedge clockp2);
    reset = 1'b1; cmd_valid_in = 1'b0; command_in = 16'h0000; branch_taken = 1'b0;
    @(posedge clockp2);
    #1;
    chk("t5 rst halted", 32'(halted), 32'h0);
    chk("t5 rst pmask", 32'(pending_mask), 32'h0);
    chk("t5 rst scount", 32'(stall_count), 32'h0);
    chk("t5 rst stall", 32'(stall), 32'h0);
    @(negedge clockp2);
    reset = 1'b0;
    step("t5 post", 16'hD100, 1, 0, 0, 16'hD100, 1, 0);

    // T6: self-dependent r1 writer on the WB_DIST=7 instance, 7 stall cycles per 8
    @(negedge clockp2);
    reset_s = 1'b0; command_s = 16'hC900; cmd_valid_s = 1'b1;
    repeat (800) @(posedge clockp2);
    #1 chk("t6 scount800", 32'(stall_count_s), 32'd700);
    repeat (75203) @(posedge clockp2);
    #1;
    chk("t6 sat", 32'(stall_count_s), 32'hFFFF);
    chk("t6 midstall", 32'(stall_s), 32'h1);
    @(negedge clockp2);
    reset_s = 1'b1;
    @(posedge clockp2);
    #1;
    chk("t6 rst scount", 32'(stall_count_s), 32'h0);
    chk("t6 rst pmask", 32'(pending_mask_s), 32'h0);
    chk("t6 rst vout", 32'(cmd_valid_out_s), 32'h0);
    chk("t6 rst halted", 32'(halted_s), 32'h0);
    @(negedge clockp2);
    reset_s = 1'b0; command_s = 16'hC300;
    #1 chk("t6 nx stall", 32'(stall_s), 32'h0);
    @(posedge clockp2);
    #1;
    chk("t6 nx cmd_out", 32'(command_out_s), 32'hC300);
    chk("t6 nx vout", 32'(cmd_valid_out_s), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
